// File: rtl/fp_defs.sv
// Shared float32 field widths, exponent bias and converter state encodings.
package fp_defs;

   localparam int FP_BIAS  = 127;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit significand; combinational.
// A carry out of 24 bits renormalises to 1.0 and bumps the exponent.
module fp_round_rne
   import fp_defs::*;
(
   input  logic [FP_MAN_W:0]   kept_i,
   input  logic                g_i,
   input  logic                s_i,
   input  logic [FP_EXP_W:0]   e_i,
   output logic [FP_MAN_W-1:0] man_o,
   output logic [FP_EXP_W:0]   exp_o
);

   logic             inc;
   logic [FP_MAN_W+1:0] sum;

   assign inc = g_i & (s_i | kept_i[0]);
   assign sum = {1'b0, kept_i} + {{(FP_MAN_W+1){1'b0}}, inc};

   always_comb begin
      man_o = sum[FP_MAN_W-1:0];
      exp_o = e_i;
      if (sum[FP_MAN_W+1]) begin
         man_o = '0;
         exp_o = e_i + 1'b1;
      end
   end

endmodule

// File: rtl/product_to_fp32.sv
// Unsigned 32-bit product to float32, normalised one left shift per cycle.
// FP_ROUND_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module product_to_fp32 #(
   parameter int IN_W    = 32,
   parameter int FP_BIAS = 127
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_data,
   output logic            busy
);
   import fp_defs::*;

   state_t              state_q;
   logic [IN_W-1:0]     m_q;
   logic [FP_EXP_W:0]   e_q;
   logic [31:0]         out_data_q;

   logic [FP_MAN_W-1:0] man_r;
   logic [FP_EXP_W:0]   exp_r;

`ifdef FP_ROUND_EN
   fp_round_rne u_round (
      .kept_i (m_q[IN_W-1:IN_W-24]),
      .g_i    (m_q[IN_W-25]),
      .s_i    (|m_q[IN_W-26:0]),
      .e_i    (e_q),
      .man_o  (man_r),
      .exp_o  (exp_r)
   );
`else
   assign man_r = m_q[IN_W-2:IN_W-24];
   assign exp_r = e_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         m_q        <= '0;
         e_q        <= '0;
         out_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  m_q <= in_data;
                  e_q <= (FP_EXP_W+1)'(FP_BIAS + IN_W - 1);
                  if (in_data == '0) begin
                     out_data_q <= '0;
                     state_q    <= ST_HOLD;
                  end else begin
                     state_q    <= ST_NORM;
                  end
               end
            end
            ST_NORM: begin
               if (m_q[IN_W-1]) begin
                  state_q <= ST_ROUND;
               end else begin
                  m_q <= m_q << 1;
                  e_q <= e_q - 1'b1;
               end
            end
            ST_ROUND: begin
               out_data_q <= {1'b0, exp_r[FP_EXP_W-1:0], man_r};
               state_q    <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Handshake outputs depend only on the registered state.
   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_HOLD);
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_product_to_fp32.sv
// Self-checking bench for product_to_fp32 against an arithmetic reference model.
module tb_product_to_fp32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   product_to_fp32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic int count_lz(input logic [31:0] d);
      int n = 0;
      for (int i = 31; i >= 0; i--) begin
         if (d[i]) return n;
         n++;
      end
      return 32;
   endfunction

   // Value = d exactly; float = 2^(e-127) * kept/2^23 with kept the top 24 significant bits.
   function automatic logic [31:0] ref_fp(input logic [31:0] d);
      int          lz;
      logic [31:0] m;
      int          e;
      longint      kept;
      longint      rem;
      if (d == 0) return 32'h0;
      lz   = count_lz(d);
      m    = d << lz;
      e    = 127 + 31 - lz;
      kept = longint'(m) / 256;
      rem  = longint'(m) % 256;
`ifdef FP_ROUND_EN
      if (rem > 128 || (rem == 128 && (kept % 2) == 1)) kept = kept + 1;
      if (kept == 64'd16777216) begin
         kept = 64'd8388608;
         e    = e + 1;
      end
`else
      if (rem < 0) kept = 0;
`endif
      return {1'b0, 8'(e), 23'(kept % 8388608)};
   endfunction

   function automatic int ref_lat(input logic [31:0] d);
      return (d == 0) ? 1 : count_lz(d) + 3;
   endfunction

   // Accept d, return result and latency in cycles after the accept edge.
   task automatic run_conv(input logic [31:0] d, input int hold, output logic [31:0] res,
                           output int lat, output bit tmo);
      int cnt = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && cnt < 60) begin
         @(posedge clk); #1;
         cnt++;
      end
      tmo = !out_valid;
      lat = cnt + 1;
      res = out_data;
      repeat (hold) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset: out_valid=%b in_ready=%b busy=%b out_data=%h required 0 1 0 00000000",
                  out_valid, in_ready, busy, out_data);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [31:0] vin [6];
      logic [31:0] vexp[6];
      int          vlat[6];
      logic [31:0] res;
      int          lat;
      bit          tmo;
      vin[0] = 32'h80000000; vexp[0] = 32'h4F000000; vlat[0] = 3;
      vin[1] = 32'h00000001; vexp[1] = 32'h3F800000; vlat[1] = 34;
      vin[2] = 32'h00000000; vexp[2] = 32'h00000000; vlat[2] = 1;
`ifdef FP_ROUND_EN
      vin[3] = 32'hFFFFFFFF; vexp[3] = 32'h4F800000; vlat[3] = 3;
      vin[4] = 32'h01000001; vexp[4] = 32'h4B800000; vlat[4] = 10;
      vin[5] = 32'h01000003; vexp[5] = 32'h4B800002; vlat[5] = 10;
`else
      vin[3] = 32'hFFFFFFFF; vexp[3] = 32'h4F7FFFFF; vlat[3] = 3;
      vin[4] = 32'h01000001; vexp[4] = 32'h4B800000; vlat[4] = 10;
      vin[5] = 32'h01000003; vexp[5] = 32'h4B800001; vlat[5] = 10;
`endif
      for (int i = 0; i < 6; i++) begin
         run_conv(vin[i], i % 3, res, lat, tmo);
         n_cmp++;
         if (tmo || res !== vexp[i] || lat != vlat[i]) begin
            n_fail++;
            $display("FAIL directed[%0d] in=%h: got %h at cycle %0d (timeout=%0d), required %h at cycle %0d",
                     i, vin[i], res, lat, tmo, vexp[i], vlat[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] d, res;
      int          lat;
      bit          tmo;
      for (int i = 0; i < 40; i++) begin
         d = $urandom() >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) d = 32'h0;
         run_conv(d, $urandom_range(0, 3), res, lat, tmo);
         n_cmp++;
         if (tmo || res !== ref_fp(d) || lat != ref_lat(d)) begin
            n_fail++;
            $display("FAIL random[%0d] in=%h: got %h at cycle %0d (timeout=%0d), required %h at cycle %0d",
                     i, d, res, lat, tmo, ref_fp(d), ref_lat(d));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d1 = 32'h12345678;
      logic [31:0] d2 = 32'h00000ABC;
      logic [31:0] res;
      int          cnt = 0;
      in_valid = 1'b1; in_data = d1;
      @(posedge clk); #1;
      in_data = d2;  // keep requesting while the first conversion is in flight
      while (!out_valid && cnt < 60) begin @(posedge clk); #1; cnt++; end
      n_cmp++;
      if (!out_valid) begin
         n_fail++;
         $display("FAIL bp_valid: out_valid=%b required 1 within 60 cycles", out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (out_data !== ref_fp(d1) || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: out_data=%h in_ready=%b busy=%b out_valid=%b required %h 0 1 1",
                     i, out_data, in_ready, busy, out_valid, ref_fp(d1));
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_handshake_ready: in_ready=%b required 0", in_ready);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_after: in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 60) begin @(posedge clk); #1; cnt++; end
      res = out_data;
      n_cmp++;
      if (res !== ref_fp(d2) || cnt + 1 != ref_lat(d2)) begin
         n_fail++;
         $display("FAIL bp_second: got %h at cycle %0d, required %h at cycle %0d", res, cnt + 1, ref_fp(d2), ref_lat(d2));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d1, d2;
      int          acc[2];
      int          nacc;
      for (int t = 0; t < 4; t++) begin
         d1 = (t == 0) ? 32'h0 : ($urandom() | 32'h1) >> $urandom_range(0, 31);
         d2 = $urandom();
         nacc = 0;
         in_valid = 1'b1; in_data = d1; out_ready = 1'b1;
         for (int c = 0; c < 80 && nacc < 2; c++) begin
            if (in_ready) begin
               acc[nacc] = c;
               nacc++;
            end
            @(posedge clk); #1;
            if (nacc == 1) in_data = d2;
         end
         in_valid = 1'b0;
         n_cmp++;
         if (nacc != 2 || acc[1] - acc[0] != ref_lat(d1) + 1) begin
            n_fail++;
            $display("FAIL back_to_back[%0d] in=%h: accepts=%0d spacing=%0d required 2 accepts spacing %0d",
                     t, d1, nacc, acc[1] - acc[0], ref_lat(d1) + 1);
         end
         repeat (40) @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset_mid_norm();
      bit seen = 0;
      in_valid = 1'b1; in_data = 32'h00000100;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_norm: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
      end
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen = 1;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (seen) begin
         n_fail++;
         $display("FAIL reset_drop: out_valid seen=%0d required 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_norm();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
